// File: rtl/motores_alternados.sv
`default_nettype none
// ============================================================================
// Module      : motores_alternados
// Description : Two-motor duty-sharing controller. START runs M1 first, and the
//               active motor swaps every alternation period. Optional both-off
//               gap at each swap when MOTORES_DEADTIME_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module motores_alternados #(
    parameter int unsigned CLK_HZ      = 25_000_000,
    parameter int unsigned T_NORMAL_S  = 30,
    parameter int unsigned T_TEST_S    = 3,
    parameter int unsigned DEAD_CYCLES = 2
) (
    input  logic clk,
    input  logic I1,
    input  logic I2,
    input  logic I3,
    input  logic I4,
    input  logic I5,
    output logic O1,
    output logic O2,
    output logic O3,
    output logic O4,
    output logic O5
);

    localparam longint unsigned c_MAX_S   = (T_NORMAL_S > T_TEST_S) ? 64'(T_NORMAL_S) : 64'(T_TEST_S);
    localparam longint unsigned c_MAX_T   = c_MAX_S * 64'(CLK_HZ);
    // The counter also times the dead gap, so it must cover DEAD_CYCLES too.
    localparam longint unsigned c_MAX_CYC = (c_MAX_T > 64'(DEAD_CYCLES)) ? c_MAX_T : 64'(DEAD_CYCLES);
    localparam int              c_CNT_W   = $clog2(c_MAX_CYC) + 1;

    localparam logic [c_CNT_W-1:0] c_LIM_N = c_CNT_W'(64'(T_NORMAL_S) * 64'(CLK_HZ));
    localparam logic [c_CNT_W-1:0] c_LIM_T = c_CNT_W'(64'(T_TEST_S) * 64'(CLK_HZ));
    localparam logic [c_CNT_W-1:0] c_ONE   = {{(c_CNT_W-1){1'b0}}, 1'b1};
    localparam logic [c_CNT_W-1:0] c_ZERO  = '0;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN_M1 = 2'd1,
        S_RUN_M2 = 2'd2,
        S_DEAD   = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [c_CNT_W-1:0] r_cnt;
    logic [c_CNT_W-1:0] w_cnt_next;
    logic [c_CNT_W-1:0] w_lim_m1;
    logic               w_swap;

    // Limit follows I4 live, so a mode change affects the running count at once.
    assign w_lim_m1 = (I4 ? c_LIM_T : c_LIM_N) - c_ONE;
    assign w_swap   = (r_cnt >= w_lim_m1);

`ifdef MOTORES_DEADTIME_EN
    localparam logic [c_CNT_W-1:0] c_DEAD_LAST = c_CNT_W'(DEAD_CYCLES - 1);
    logic r_to_m2;
    logic w_to_m2_next;
`endif

    always_comb begin
        w_next     = r_state;
        w_cnt_next = r_cnt;
`ifdef MOTORES_DEADTIME_EN
        w_to_m2_next = r_to_m2;
`endif
        if (I2 || I5) begin
            w_next     = S_IDLE;
            w_cnt_next = c_ZERO;
        end else begin
            case (r_state)
                S_IDLE: begin
                    w_cnt_next = c_ZERO;
                    if (I1) w_next = S_RUN_M1;
                end
                S_RUN_M1: begin
                    if (w_swap) begin
                        w_cnt_next = c_ZERO;
`ifdef MOTORES_DEADTIME_EN
                        w_next       = S_DEAD;
                        w_to_m2_next = 1'b1;
`else
                        w_next = S_RUN_M2;
`endif
                    end else begin
                        w_cnt_next = r_cnt + c_ONE;
                    end
                end
                S_RUN_M2: begin
                    if (w_swap) begin
                        w_cnt_next = c_ZERO;
`ifdef MOTORES_DEADTIME_EN
                        w_next       = S_DEAD;
                        w_to_m2_next = 1'b0;
`else
                        w_next = S_RUN_M1;
`endif
                    end else begin
                        w_cnt_next = r_cnt + c_ONE;
                    end
                end
`ifdef MOTORES_DEADTIME_EN
                S_DEAD: begin
                    if (r_cnt >= c_DEAD_LAST) begin
                        w_next     = r_to_m2 ? S_RUN_M2 : S_RUN_M1;
                        w_cnt_next = c_ZERO;
                    end else begin
                        w_cnt_next = r_cnt + c_ONE;
                    end
                end
`endif
                default: begin
                    w_next     = S_IDLE;
                    w_cnt_next = c_ZERO;
                end
            endcase
        end
    end

    // Outputs are decoded from the next state so they change with the state register.
    always_ff @(posedge clk) begin
        if (I3) begin
            r_state <= S_IDLE;
            r_cnt   <= c_ZERO;
            O1      <= 1'b0;
            O2      <= 1'b0;
            O3      <= 1'b0;
            O4      <= 1'b0;
            O5      <= 1'b0;
`ifdef MOTORES_DEADTIME_EN
            r_to_m2 <= 1'b0;
`endif
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt_next;
            O1      <= (w_next == S_RUN_M1);
            O2      <= (w_next == S_RUN_M2);
            O3      <= (w_next != S_IDLE);
            O4      <= I4;
            O5      <= I5;
`ifdef MOTORES_DEADTIME_EN
            r_to_m2 <= w_to_m2_next;
`endif
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_motores_alternados.sv
`default_nettype none
// ============================================================================
// Module      : tb_motores_alternados
// Description : Scoreboard bench for motores_alternados with a timestamp model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_motores_alternados;

    localparam int unsigned c_CLK_HZ = 10;
    localparam int unsigned c_T_N    = 5;
    localparam int unsigned c_T_T    = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic I1 = 1'b0, I2 = 1'b0, I3 = 1'b0, I4 = 1'b0, I5 = 1'b0;
    logic O1, O2, O3, O4, O5;

    motores_alternados #(
        .CLK_HZ     (c_CLK_HZ),
        .T_NORMAL_S (c_T_N),
        .T_TEST_S   (c_T_T),
        .DEAD_CYCLES(2)
    ) dut (
        .clk(clk), .I1(I1), .I2(I2), .I3(I3), .I4(I4), .I5(I5),
        .O1(O1), .O2(O2), .O3(O3), .O4(O4), .O5(O5)
    );

    typedef struct {
        logic [4:0] o;
        longint     cyc;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;

    // Reference: a motor is on for LIMIT cycles measured from the edge it started on.
    bit     m_run   = 1'b0;
    int     m_motor = 1;
    longint m_cyc   = 0;
    longint m_start = 0;

    logic s1 = 1'b0, s2 = 1'b0, s3 = 1'b0, s4 = 1'b0, s5 = 1'b0;

    task automatic step();
        exp_t   e;
        longint lim;
        logic   l4, l5;
        @(negedge clk);
        I1 = s1; I2 = s2; I3 = s3; I4 = s4; I5 = s5;
        m_cyc++;
        l4 = s4;
        l5 = s5;
        if (s3) begin
            m_run = 1'b0;
            l4 = 1'b0;
            l5 = 1'b0;
        end else if (s2 || s5) begin
            m_run = 1'b0;
        end else if (!m_run) begin
            if (s1) begin
                m_run   = 1'b1;
                m_motor = 1;
                m_start = m_cyc;
            end
        end else begin
            lim = longint'(s4 ? c_T_T : c_T_N) * longint'(c_CLK_HZ);
            if (m_cyc - m_start >= lim) begin
                m_motor = 3 - m_motor;
                m_start = m_cyc;
            end
        end
        e.o   = {m_run && m_motor == 1, m_run && m_motor == 2, m_run, l4, l5};
        e.cyc = m_cyc;
        q.push_back(e);
    endtask

    task automatic cyc(input int n);
        repeat (n) step();
    endtask

    // Advance until the model shows motor m running for `el` cycles, bounded.
    task automatic wait_model(input int m, input longint el, input int budget);
        int n = 0;
        while (!(m_run && m_motor == m && (m_cyc - m_start) == el) && n < budget) begin
            step();
            n++;
        end
        if (n >= budget) begin
            errors++;
            checks++;
            $display("FAIL wait_model motor=%0d el=%0d: not reached within %0d cycles", m, el, budget);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (q.size() > 0) begin
                e = q.pop_front();
                checks++;
                if ({O1, O2, O3, O4, O5} !== e.o) begin
                    errors++;
                    $display("FAIL outputs cyc=%0d O1..O5 got=%b exp=%b", e.cyc, {O1, O2, O3, O4, O5}, e.o);
                end
                checks++;
                if (O1 && O2) begin
                    errors++;
                    $display("FAIL overlap cyc=%0d O1=%b O2=%b exp not both 1", e.cyc, O1, O2);
                end
            end
        end
    end

    initial begin : stimulus
        s3 = 1'b1; cyc(2);
        s3 = 1'b0; cyc(20);
        s1 = 1'b1; cyc(3);
        s1 = 1'b0; cyc(130);
        // Test mode raised after the count already passed the shorter limit
        wait_model(1, 35, 200);
        s4 = 1'b1; cyc(70);
        s4 = 1'b0; cyc(120);
        wait_model(2, 5, 200);
        s2 = 1'b1; cyc(3);
        s2 = 1'b0; cyc(40);
        s1 = 1'b1; cyc(1);
        s1 = 1'b0; cyc(60);
        s3 = 1'b1; cyc(1);
        s3 = 1'b0; cyc(5);
        s1 = 1'b1; cyc(1);
        s1 = 1'b0; cyc(10);
        s5 = 1'b1; cyc(5);
        repeat (3) begin
            s1 = 1'b1; cyc(2);
            s1 = 1'b0; cyc(4);
        end
        s5 = 1'b0; cyc(5);
        s1 = 1'b1; cyc(1);
        s1 = 1'b0; cyc(15);
        s2 = 1'b1; cyc(2);
        s1 = 1'b1; cyc(3);
        s1 = 1'b0; s2 = 1'b0; cyc(5);

        repeat (2000) begin
            if ($urandom_range(0, 299) == 0) s5 = ~s5;
            if ($urandom_range(0, 99) == 0)  s4 = ~s4;
            s3 = ($urandom_range(0, 399) == 0);
            s2 = ($urandom_range(0, 149) == 0);
            s1 = ($urandom_range(0, 19) == 0);
            step();
        end
        s1 = 1'b0; s2 = 1'b0; s3 = 1'b0; s4 = 1'b0; s5 = 1'b0;

        for (int i = 0; i < 10; i++) begin
            if (q.size() == 0) break;
            @(negedge clk);
        end
        if (q.size() != 0) begin
            errors++;
            checks++;
            $display("FAIL drain pending=%0d exp=0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
